// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the MIPS32 front-end blocks.
//   - fetch_state_t : instruction-fetch FSM states
//   - RESET_PC_DEF / NOP_WORD_DEF : default reset PC and bubble instruction
//   - OP_* : primary opcode values, shared with the main decoder
//   - branch_offset() : sign-extended, word-scaled branch displacement
package core_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;

    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// npc_calc: combinational next-PC arithmetic for the fetch stage.
//   pc          in  : current fetch PC
//   instr_pc    in  : PC of the IF/ID instruction
//   instr       in  : IF/ID instruction word
//   j           in  : select jump target over branch target
//   pc_next_seq out : pc + 4 (sequential fetch)
//   pc_plus4    out : instr_pc + 4
//   target      out : redirect target (jump or branch), 32-bit wrapping
module npc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr_pc,
    input  logic [31:0] instr,
    input  logic        j,
    output logic [31:0] pc_next_seq,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    logic [31:0]        jump_tgt;
    logic [31:0]        br_tgt;
    logic signed [31:0] br_off;

    always_comb begin
        pc_next_seq = pc + 32'd4;
        pc_plus4    = instr_pc + 32'd4;
        // Jump keeps the 256 MB region of the delay-slot-free successor.
        jump_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};
        br_off      = branch_offset(instr[15:0]);
        br_tgt      = pc_plus4 + 32'(br_off);
        target      = j ? jump_tgt : br_tgt;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: MIPS32 instruction-fetch stage with IF/ID register.
//   clk, rst          : core clock, synchronous active-high reset
//   imem_req/addr     : fetch request, held stable until imem_rdy
//   imem_rdy/rdata    : memory response (may come in the request cycle)
//   stall             : decode cannot accept, IF/ID holds
//   j, br_taken       : redirect requests decoded from the IF/ID instruction
//   instr, opcode     : IF/ID instruction and its primary opcode
//   instr_pc, pc_plus4: PC of instr and that PC + 4
//   instr_valid       : IF/ID holds a real instruction
// A one-entry skid buffer absorbs a word accepted in a stalled cycle; the
// DROP state waits out an outstanding fetch made stale by a redirect.
module ifetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        j,
    input  logic        br_taken,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         pending;
    logic [31:0]  target_q;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    logic [31:0]  instr_p1;
    logic [31:0]  instr_pc_p1;
    logic         vld_p1;

    logic         accept;
    logic         redirect;
    logic [31:0]  pc_next_seq;
    logic [31:0]  target;

    npc_calc u_npc (
        .pc          (pc),
        .instr_pc    (instr_pc_p1),
        .instr       (instr_p1),
        .j           (j),
        .pc_next_seq (pc_next_seq),
        .pc_plus4    (pc_plus4),
        .target      (target)
    );

    // A raised request stays up while pending, even if stall arrives later.
    assign imem_req  = !rst && (pending || state == DROP || (state == FETCH && !stall));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_rdy;
    assign redirect  = vld_p1 && !stall && (j || br_taken);

    assign instr       = instr_p1;
    assign instr_pc    = instr_pc_p1;
    assign instr_valid = vld_p1;
    assign opcode      = vld_p1 ? instr_p1[31:26] : 6'd0;

    // Fetch request (p0) -> IF/ID register (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            vld_p1      <= 1'b0;
            instr_p1    <= NOP_WORD;
            instr_pc_p1 <= 32'd0;
        end else begin
            pending <= imem_req && !imem_rdy;
            unique case (state)
                FETCH: begin
                    if (accept && redirect) begin
                        pc       <= target;
                        vld_p1   <= 1'b0;
                        instr_p1 <= NOP_WORD;
                    end else if (redirect) begin
                        // Request is up but unanswered: it must complete at
                        // the old address before the target can be fetched.
                        target_q <= target;
                        vld_p1   <= 1'b0;
                        instr_p1 <= NOP_WORD;
                        state    <= DROP;
                    end else if (accept && stall) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc;
                        pc         <= pc_next_seq;
                        state      <= SKID;
                    end else if (accept) begin
                        instr_p1    <= imem_rdata;
                        instr_pc_p1 <= pc;
                        vld_p1      <= 1'b1;
                        pc          <= pc_next_seq;
                    end else if (!stall) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= NOP_WORD;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        if (redirect) begin
                            pc       <= target;
                            vld_p1   <= 1'b0;
                            instr_p1 <= NOP_WORD;
                        end else begin
                            instr_p1    <= skid_instr;
                            instr_pc_p1 <= skid_pc;
                            vld_p1      <= 1'b1;
                        end
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_rdy) begin
                        pc    <= target_q;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam logic [5:0] M_OP_J   = 6'd2;
    localparam logic [5:0] M_OP_BEQ = 6'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        j = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    int checks   = 0;
    int failures = 0;
    int retired  = 0;

    int          max_lat  = 0;
    bit          stall_en = 1'b0;
    bit          busy     = 1'b0;
    logic [31:0] busy_addr;
    int          lat, cnt;
    logic [31:0] seed;

    logic [31:0] exp_pc[$];
    logic [31:0] exp_w[$];

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .j           (j),
        .br_taken    (br_taken),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory image: a deterministic mix of jumps, BEQs and plain ops.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        h = a ^ (a >> 15) ^ seed;
        h = h * 32'h2C1B_3C6D;
        h = h ^ (h >> 12);
        h = h * 32'h297A_2D39;
        h = h ^ (h >> 15);
        if (h[31:29] == 3'd0)      return {M_OP_J, h[25:0]};
        else if (h[31:29] == 3'd1) return {M_OP_BEQ, h[25:0]};
        else                       return {3'b001, h[28:26], h[25:0]};
    endfunction

    // Architectural flow: BEQ is taken when bit 16 of the word is set.
    function automatic bit is_taken(input logic [31:0] w);
        return (w[31:26] == M_OP_J) || (w[31:26] == M_OP_BEQ && w[16]);
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] w);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = p + 32'd4;
        off = {{14{w[15]}}, w[15:0], 2'b00};
        if (w[31:26] == M_OP_J)                 return {p4[31:28], w[25:0], 2'b00};
        else if (w[31:26] == M_OP_BEQ && w[16]) return p4 + off;
        else                                    return p4;
    endfunction

    task automatic gen_trace(input int n);
        logic [31:0] p;
        exp_pc.delete();
        exp_w.delete();
        p = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(p);
            exp_w.push_back(word_at(p));
            p = next_pc(p, word_at(p));
        end
    endtask

    // Decode side and memory responder.
    initial begin
        forever begin
            @(negedge clk);
            stall    = stall_en && ($urandom_range(0, 99) < 30);
            j        = (instr_valid && opcode == M_OP_J) ||
                       ((stall || !instr_valid) && $urandom_range(0, 3) == 0);
            br_taken = (instr_valid && opcode == M_OP_BEQ && instr[16]) ||
                       ((stall || !instr_valid) && $urandom_range(0, 3) == 0);
            #1;
            if (rst) begin
                busy     = 1'b0;
                imem_rdy = 1'b0;
            end else if (imem_req) begin
                check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (busy) begin
                    check("addr_hold", imem_addr, busy_addr);
                end else begin
                    busy      = 1'b1;
                    busy_addr = imem_addr;
                    lat       = $urandom_range(0, max_lat);
                    cnt       = 0;
                end
                if (cnt == lat) begin
                    imem_rdy   = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_rdy   = 1'b0;
                    imem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                if (busy) check("req_held", {31'd0, imem_req}, 32'd1);
                busy     = 1'b0;
                imem_rdy = 1'b0;
            end
        end
    end

    // Monitor: every instruction decode consumes must be the next one in
    // program order.
    initial begin
        logic [31:0] ep, ew;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_valid && !stall) begin
                if (exp_pc.size() == 0) begin
                    check("trace_underrun", 32'd1, 32'd0);
                end else begin
                    ep = exp_pc.pop_front();
                    ew = exp_w.pop_front();
                    check("instr_pc", instr_pc, ep);
                    check("instr", instr, ew);
                    check("opcode", {26'd0, opcode}, {26'd0, ew[31:26]});
                    check("pc_plus4", pc_plus4, ep + 32'd4);
                    retired++;
                end
            end
        end
    end

    initial begin
        logic [31:0] w0;
        logic [31:0] exp3;
        int          k;
        int          r0;
        seed = $urandom;
        gen_trace(4000);
        repeat (3) @(posedge clk);

        @(negedge clk);
        #3;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        // Zero-wait memory, no stalls: back-to-back fetch.
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("c1_req", {31'd0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'd0);
        check("c1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        #3;
        check("c2_addr", imem_addr, 32'd4);
        check("c2_valid", {31'd0, instr_valid}, 32'd1);
        check("c2_instr_pc", instr_pc, 32'd0);
        w0   = word_at(32'd0);
        exp3 = is_taken(w0) ? next_pc(32'd0, w0) : 32'd8;
        @(negedge clk);
        #3;
        check("c3_addr", imem_addr, exp3);
        repeat (100) @(posedge clk);

        // Random latency and stalls.
        max_lat  = 3;
        stall_en = 1'b1;
        repeat (1500) @(posedge clk);

        // Reset while a fetch is outstanding.
        k = 0;
        while (!busy && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("busy_found", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        #3;
        check("post_rst_req", {31'd0, imem_req}, 32'd0);
        check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("post_rst_opcode", {26'd0, opcode}, 32'd0);
        gen_trace(3000);
        r0 = retired;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("restart_addr", imem_addr, 32'd0);
        repeat (1200) @(posedge clk);
        check("progress", {31'd0, (retired - r0) > 150}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the MIPS32 core, directly upstream of the main decoder.
- Owns the PC and drives a variable-latency instruction-memory request/ready interface.
- Holds the IF/ID pipeline register and presents the 6-bit opcode to the decoder.
- Resolves jump/branch redirects fed back from decode (no delay slot). Absorbs downstream stalls with a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instr value presented when IF/ID is invalid or reset

Ports:
clk  in  1  single core clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; held with imem_addr stable until imem_rdy
imem_addr  out  32  word-aligned fetch address (current PC)
imem_rdy  in  1  response valid this cycle; may assert in the same cycle as imem_req
imem_rdata  in  32  instruction word, valid when imem_rdy
stall  in  1  decode cannot accept; IF/ID must hold
j  in  1  jump decoded from the IF/ID instruction
br_taken  in  1  branch decoded and condition true for the IF/ID instruction
instr  out  32  IF/ID instruction
opcode  out  6  instr[31:26], feeds the main decoder
instr_pc  out  32  PC of instr
pc_plus4  out  32  instr_pc + 4
instr_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst high at clk edge):
  - pc=RESET_PC, state=FETCH, instr=NOP_WORD, instr_pc=0, instr_valid=0, skid empty.
  - imem_req is forced 0 while rst=1. First request issues the cycle after rst falls.
  - Reset mid-request abandons the outstanding fetch; the memory must tolerate a dropped request.
- States: FETCH, SKID, DROP. The internal flag pending is set when imem_req=1 and imem_rdy=0.
- imem_req = !rst && (pending || state==DROP || (state==FETCH && !stall)). imem_addr = pc. Once raised, req and addr are held until rdy.
- Accept = imem_req && imem_rdy.
- redirect = instr_valid && !stall && (j || br_taken). Redirects are ignored while stall=1.
- Target computation, 32-bit, overflow wraps:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}
  - branch: pc_plus4 + (sign-extended instr[15:0] << 2)
  - j has priority if j and br_taken are both asserted.
- FETCH transitions, in priority order:
  - accept && redirect: drop rdata, pc<=target, instr_valid<=0.
  - redirect && pending (no rdy): target_q<=target, instr_valid<=0, go to DROP.
  - accept && stall: skid<= {rdata, pc}, pc<=pc+4, go to SKID; IF/ID holds.
  - accept && !stall: IF/ID<= {rdata, pc}, instr_valid<=1, pc<=pc+4.
  - no accept && !stall: instr_valid<=0 (bubble), instr<=NOP_WORD.
  - no accept && stall: IF/ID holds.
- SKID: imem_req=0.
  - stall: hold everything.
  - !stall && redirect: discard skid, pc<=target, instr_valid<=0, go to FETCH.
  - !stall, no redirect: IF/ID<=skid, instr_valid<=1, go to FETCH.
- DROP: imem_req=1 at the old pc. IF/ID stays invalid regardless of stall.
  - On imem_rdy: discard rdata, pc<=target_q, go to FETCH.
- Latency:
  - Zero-wait memory: one instruction per cycle; rdata appears in IF/ID one cycle after accept.
  - Redirect penalty: one bubble with zero-wait memory, plus the remaining wait cycles when pending.
- pc[1:0] is always 0 (targets are word-aligned by construction). PC wraps 32'hFFFF_FFFC -> 0.
- opcode and pc_plus4 are combinational from IF/ID; opcode=0 when invalid (decoder sees NOP_WORD).

Decomposition:
- Shared package core_pkg:
  - FSM state enum {FETCH, SKID, DROP}
  - RESET_PC default, NOP_WORD
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5 (shared with the decoder)
- One natural sub-module: npc_calc, the combinational next-PC/target adder (pc+4, jump target, branch target, select). All sequential logic stays in ifetch_unit.

Test Plan:
- Reset, zero-wait memory returning addr-as-data: imem_addr 0,4,8 on consecutive cycles; instr_valid=1 from cycle 2; instr_pc tracks 0,4,8.
- 3-cycle memory latency: imem_req held high, imem_addr=0 stable for 3 cycles; instr_valid pulses once per accept with bubbles between.
- Stall asserted in the accept cycle for word at 0x8: skid captures it, imem_req=0; IF/ID holds 0x4 until stall drops, then shows 0x8, and fetch resumes at 0xC.
- IF/ID = J 0x0000040 at pc 0x10, zero-wait: next imem_addr=0x100; the word fetched from 0x14 is dropped; one bubble.
- BEQ taken at pc 0x20, imm=0xFFFE, memory pending 2 cycles: state DROP; addr 0x24 held until rdy, data discarded, then imem_addr=0x1C.
- rst asserted while pending in DROP: next cycle imem_req=0, instr_valid=0; after release the first imem_addr is RESET_PC.
